// File: rtl/btn_repeat_pkg.sv
// btn_repeat_pkg: state encoding, default timing constants and a sizing helper
package btn_repeat_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_HOLD, S_REPEAT, S_WAIT0} state_t;
  localparam int DEF_DB_CNT   = 1_000_000;
  localparam int DEF_HOLD_CNT = 50_000_000;
  localparam int DEF_RPT_CNT  = 10_000_000;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level, sync active-low reset
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic r_s1;
  always_ff @(posedge clk)
    if (!reset) {q, r_s1} <= 2'b00;
    else        {q, r_s1} <= {r_s1, d};
endmodule

// File: rtl/btn_repeat.sv
// btn_repeat: debounced push-button with press tick, hold delay and auto-repeat ticks
module btn_repeat
  import btn_repeat_pkg::*;
#(
  parameter int DB_CNT   = DEF_DB_CNT,
  parameter int HOLD_CNT = DEF_HOLD_CNT,
  parameter int RPT_CNT  = DEF_RPT_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic press_tick,
  output logic rep_tick
);
  localparam int CNT_MAX = max3(DB_CNT, HOLD_CNT, RPT_CNT);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_s2, w_clr, w_press, w_rep, w_db;
  logic          w_db_done, w_hold_done, w_rpt_done;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(sw), .q(w_s2));
  assign w_db_done   = r_cnt == CW'(DB_CNT - 1);
  assign w_hold_done = r_cnt == CW'(HOLD_CNT - 1);
  assign w_rpt_done  = r_cnt == CW'(RPT_CNT - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      db_level   <= 1'b0;
      press_tick <= 1'b0;
      rep_tick   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_next != r_state || w_clr || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      db_level   <= w_db;
      press_tick <= w_press;
      rep_tick   <= w_rep;
    end
  // w_clr marks a repeat period rollover while staying in S_REPEAT
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = w_s2 ? S_WAIT1 : S_IDLE;
      S_WAIT1:  w_next = !w_s2 ? S_IDLE : (w_db_done ? S_HOLD : S_WAIT1);
      S_HOLD:   w_next = !w_s2 ? S_WAIT0 : (w_hold_done ? S_REPEAT : S_HOLD);
      S_REPEAT: begin
        w_next = w_s2 ? S_REPEAT : S_WAIT0;
        w_clr  = w_s2 && w_rpt_done;
      end
      S_WAIT0:  w_next = w_s2 ? S_HOLD : (w_db_done ? S_IDLE : S_WAIT0);
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_press = r_state == S_WAIT1 && w_next == S_HOLD;
    w_rep   = w_press || (r_state == S_HOLD && w_next == S_REPEAT) || w_clr;
    w_db    = w_next == S_HOLD || w_next == S_REPEAT || w_next == S_WAIT0;
  end
endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: table vectors, hand-written corner sequences and random stimulus vs a run-length model
module tb_btn_repeat;
  localparam int DB = 4, HD = 10, RP = 3;
  logic clk = 1'b0, reset = 1'b0, sw = 1'b0;
  logic db_level, press_tick, rep_tick;
  btn_repeat #(.DB_CNT(DB), .HOLD_CNT(HD), .RPT_CNT(RP)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(db_level), .press_tick(press_tick), .rep_tick(rep_tick)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic m_s1 = 0, m_s2 = 0, m_db = 0, m_pt = 0, m_rt = 0, prev_rt = 0;
  int run1 = 0, run0 = 0, k = 0;
  typedef struct {logic sw; logic db; logic pt; logic rt;} vec_t;
  vec_t tbl[30];
  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: sw delayed two edges, then run lengths of equal samples decide level;
  // repeats are timed from the last hold anchor (press or return from a low glitch).
  task automatic model(input logic rv, input logic sv);
    logic b;
    m_pt = 0;
    m_rt = 0;
    if (!rv) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; run1 = 0; run0 = 0; k = 0;
    end else begin
      b = m_s2; m_s2 = m_s1; m_s1 = sv;
      if (!m_db) begin
        run1 = b ? run1 + 1 : 0;
        if (run1 == DB + 1) begin m_db = 1; m_pt = 1; m_rt = 1; k = 0; run1 = 0; end
      end else if (!b) begin
        run0++;
        if (run0 == DB + 1) begin m_db = 0; run0 = 0; end
      end else if (run0 > 0) begin
        run0 = 0; k = 0;
      end else begin
        k++;
        m_rt = (k >= HD) && ((k - HD) % RP == 0);
      end
    end
  endtask
  task automatic step(input logic rv, input logic sv);
    reset = rv;
    sw = sv;
    @(posedge clk);
    model(rv, sv);
    #1;
    chk("db_level", db_level, m_db);
    chk("press_tick", press_tick, m_pt);
    chk("rep_tick", rep_tick, m_rt);
    chk("rep_tick_back_to_back", prev_rt && rep_tick, 1'b0);
    prev_rt = rep_tick;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0);
  endtask
  initial begin
    int first, cnt, seen;
    for (int i = 0; i < 30; i++)
      tbl[i] = '{1'b1, i >= 6, i == 6, i == 6 || (i >= 16 && (i - 16) % 3 == 0)};
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("reset_db", db_level, 1'b0);
    chk("reset_press", press_tick, 1'b0);
    chk("reset_rep", rep_tick, 1'b0);
    idle(3);
    for (int i = 0; i < 30; i++) begin
      step(1, tbl[i].sw);
      chk("tbl_db", db_level, tbl[i].db);
      chk("tbl_press", press_tick, tbl[i].pt);
      chk("tbl_rep", rep_tick, tbl[i].rt);
    end
    for (int j = 0; j < 12; j++) begin
      step(1, 0);
      if (j == 5) chk("tbl_rel_db_hold", db_level, 1'b1);
      if (j == 6) chk("tbl_rel_db_fall", db_level, 1'b0);
    end
    seen = 0;
    for (int i = 0; i < 13; i++) begin
      step(1, i < 3);
      seen |= int'(db_level | press_tick | rep_tick);
    end
    chk_int("short_pulse_quiet", seen, 0);
    first = -1; cnt = 0; seen = 0;
    for (int i = 0; i <= 30; i++) begin
      step(1, !(i == 12 || i == 13));
      if (i > 6 && rep_tick && first < 0) first = i;
      if (i > 6 && rep_tick) cnt++;
      if (i > 6 && (press_tick || !db_level)) seen = 1;
    end
    chk_int("glitch_first_repeat", first, 26);
    chk_int("glitch_repeat_count", cnt, 2);
    chk_int("glitch_no_release", seen, 0);
    idle(12);
    for (int i = 0; i <= 20; i++) step(1, 1);
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      step(1, 0);
      if (j >= 2 && rep_tick) cnt++;
      if (j == 5) chk("rel_db_hold", db_level, 1'b1);
      if (j == 6) chk("rel_db_fall", db_level, 1'b0);
    end
    chk_int("rel_rep_stopped", cnt, 0);
    cnt = 0; first = -1;
    for (int i = 0; i < 14; i++) begin
      step(1, 1);
      if (press_tick) begin cnt++; if (first < 0) first = i; end
    end
    chk_int("repress_count", cnt, 1);
    chk_int("repress_edge", first, 6);
    idle(12);
    for (int i = 0; i < 20; i++) step(1, 1);
    step(0, 1);
    chk("rst_mid_db", db_level, 1'b0);
    chk("rst_mid_press", press_tick, 1'b0);
    chk("rst_mid_rep", rep_tick, 1'b0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      if (press_tick && first < 0) first = i;
    end
    chk_int("rst_repress_edge", first, 6);
    idle(12);
    for (int s = 0; s < 200; s++) begin
      int len;
      logic sv;
      len = $urandom_range(1, 25);
      sv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) step(0, sv);
      for (int i = 0; i < len; i++) step(1, sv);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
